alu_control: RTL and testbench

Sequencing and routing stage that sits directly upstream of the shifter, ALU, multiplier and result mux in the execution datapath. It takes a 6-bit MIPS funct code and drives a registered 6-bit control code to each functional unit. Unselected units are parked on a NOP code, so the shifter's own `Signal == SLL` gate outputs zero. It also runs the 32-cycle MULTU sequence and raises the one-cycle HiLo write strobe at the end.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/mul_counter.sv | 41 ++++
 rtl/alu_control.sv | 101 ++++++++++
 tb/tb_alu_control.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: funct codes and FSM state encoding shared by alu_control,
// the shifter and the result mux. Rev 1.0
package alu_pkg;

  localparam logic [5:0] SLL   = 6'b000000;
  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] SLT   = 6'b101010;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] NOP   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_counter.sv
`default_nettype none
// mul_counter: MULTU iteration counter with clear/enable and a terminal flag.
// Rev 1.0
module mul_counter #(
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  // Keep at least one bit so a single-cycle configuration still elaborates.
  localparam int              CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(MUL_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// alu_control: decodes the funct code into registered per-unit control codes
// and sequences MULTU, ending with a one-cycle HiLo write strobe. Rev 1.0
module alu_control
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Signal,
  output logic [5:0] SignaltoALU,
  output logic [5:0] SignaltoSHT,
  output logic [5:0] SignaltoMULTU,
  output logic [5:0] SignaltoMUX,
  output logic       hiloWrite,
  output logic       busy
);

  state_t     state_q;
  logic [5:0] alu_q, sht_q, mul_q, mux_q;
  logic       hilo_q, busy_q;
  logic       last;

  // Counter is held at zero whenever idle, so it starts from 0 on entry to MUL.
  mul_counter #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q == IDLE),
    .en_i   ((state_q == MUL) && !last),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      alu_q   <= NOP;
      sht_q   <= NOP;
      mul_q   <= NOP;
      mux_q   <= NOP;
      hilo_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          alu_q  <= NOP;
          sht_q  <= NOP;
          mul_q  <= NOP;
          mux_q  <= NOP;
          hilo_q <= 1'b0;
          busy_q <= 1'b0;
          case (Signal)
            ADD, SUB, AND, OR, SLT: begin
              alu_q <= Signal;
              mux_q <= Signal;
            end
            SLL: begin
              sht_q <= SLL;
              mux_q <= SLL;
            end
            MFHI, MFLO: mux_q <= Signal;
            MULTU: begin
              mul_q   <= MULTU;
              busy_q  <= 1'b1;
              state_q <= MUL;
            end
            default: ;
          endcase
        end
        MUL: begin
          if (last) begin
            mul_q   <= NOP;
            hilo_q  <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          alu_q   <= NOP;
          sht_q   <= NOP;
          mul_q   <= NOP;
          mux_q   <= NOP;
          hilo_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SignaltoALU   = alu_q;
  assign SignaltoSHT   = sht_q;
  assign SignaltoMULTU = mul_q;
  assign SignaltoMUX   = mux_q;
  assign hiloWrite     = hilo_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// tb_alu_control: directed-vector bench for alu_control. Rev 1.0
module tb_alu_control;

  localparam logic [5:0] T_SLL   = 6'b000000;
  localparam logic [5:0] T_ADD   = 6'b100000;
  localparam logic [5:0] T_SUB   = 6'b100010;
  localparam logic [5:0] T_MULTU = 6'b011001;
  localparam logic [5:0] T_MFLO  = 6'b010010;
  localparam logic [5:0] T_BAD   = 6'b000111;
  localparam logic [5:0] T_NOP   = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Signal;
  logic [5:0] SignaltoALU, SignaltoSHT, SignaltoMULTU, SignaltoMUX;
  logic       hiloWrite, busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_control #(.MUL_CYCLES(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .Signal        (Signal),
    .SignaltoALU   (SignaltoALU),
    .SignaltoSHT   (SignaltoSHT),
    .SignaltoMULTU (SignaltoMULTU),
    .SignaltoMUX   (SignaltoMUX),
    .hiloWrite     (hiloWrite),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_codes(input string tag, input logic [5:0] alu, input logic [5:0] sht,
                             input logic [5:0] mul, input logic [5:0] mux);
    check({tag, ".alu"}, {26'd0, SignaltoALU}, {26'd0, alu});
    check({tag, ".sht"}, {26'd0, SignaltoSHT}, {26'd0, sht});
    check({tag, ".mul"}, {26'd0, SignaltoMULTU}, {26'd0, mul});
    check({tag, ".mux"}, {26'd0, SignaltoMUX}, {26'd0, mux});
  endtask

  initial begin
    int pulses, busy_low, overlap, first_pulse, last_pulse;

    // Reset held two cycles with ADD on the input
    reset  = 1'b1;
    Signal = T_ADD;
    for (int i = 0; i < 2; i++) begin
      step();
      check_codes("rst", T_NOP, T_NOP, T_NOP, T_NOP);
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.hilo", {31'd0, hiloWrite}, 32'd0);
    end
    reset = 1'b0;
    step();
    check_codes("add", T_ADD, T_NOP, T_NOP, T_ADD);

    // Routing
    Signal = T_SLL;  step(); check_codes("sll", T_NOP, T_SLL, T_NOP, T_SLL);
    Signal = T_SUB;  step(); check_codes("sub", T_SUB, T_NOP, T_NOP, T_SUB);
    Signal = T_MFLO; step(); check_codes("mflo", T_NOP, T_NOP, T_NOP, T_MFLO);
    Signal = T_BAD;  step(); check_codes("bad", T_NOP, T_NOP, T_NOP, T_NOP);
    check("bad.busy", {31'd0, busy}, 32'd0);

    // MULTU timing: single-cycle pulse, then ADD held
    Signal = T_MULTU; step();
    Signal = T_ADD;
    for (int k = 1; k <= 32; k++) begin
      check_codes("mul", T_NOP, T_NOP, T_MULTU, T_NOP);
      check("mul.busy", {31'd0, busy}, 32'd1);
      check("mul.hilo", {31'd0, hiloWrite}, 32'd0);
      step();
    end
    check_codes("wr", T_NOP, T_NOP, T_NOP, T_NOP);
    check("wr.busy", {31'd0, busy}, 32'd1);
    check("wr.hilo", {31'd0, hiloWrite}, 32'd1);
    step();
    check_codes("post", T_NOP, T_NOP, T_NOP, T_NOP);
    check("post.busy", {31'd0, busy}, 32'd0);
    check("post.hilo", {31'd0, hiloWrite}, 32'd0);
    step();
    check_codes("post.add", T_ADD, T_NOP, T_NOP, T_ADD);

    // Input masking while MUL runs
    Signal = T_MULTU; step();
    pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      check_codes("mask", T_NOP, T_NOP, T_MULTU, T_NOP);
      if (hiloWrite) pulses++;
      case (k % 3)
        0: Signal = T_SLL;
        1: Signal = T_ADD;
        default: Signal = T_MULTU;
      endcase
      step();
    end
    check("mask.hilo33", {31'd0, hiloWrite}, 32'd1);
    pulses++;
    Signal = T_NOP;
    for (int k = 0; k < 4; k++) begin
      step();
      if (hiloWrite) pulses++;
    end
    check("mask.pulses", pulses, 32'd1);
    check_codes("mask.end", T_NOP, T_NOP, T_NOP, T_NOP);

    // Reset at MUL count 17
    Signal = T_MULTU; step();
    Signal = T_NOP;
    for (int k = 0; k < 17; k++) step();
    check("r17.busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1; step();
    check_codes("r17", T_NOP, T_NOP, T_NOP, T_NOP);
    check("r17.busy", {31'd0, busy}, 32'd0);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (hiloWrite) pulses++;
    end
    check("r17.pulses", pulses, 32'd0);

    // Reset during WRITE
    Signal = T_MULTU; step();
    Signal = T_NOP;
    for (int k = 0; k < 32; k++) step();
    check("rw.hilo_pre", {31'd0, hiloWrite}, 32'd1);
    reset = 1'b1; step();
    check("rw.hilo", {31'd0, hiloWrite}, 32'd0);
    check("rw.busy", {31'd0, busy}, 32'd0);
    check_codes("rw", T_NOP, T_NOP, T_NOP, T_NOP);
    reset = 1'b0;

    // Back-to-back MULTU held constantly
    Signal = T_MULTU; step();
    pulses = 0; busy_low = 0; overlap = 0; first_pulse = 0; last_pulse = 0;
    for (int k = 1; k <= 102; k++) begin
      if (hiloWrite) begin
        pulses++;
        if (first_pulse == 0) first_pulse = k;
        last_pulse = k;
        if (SignaltoMULTU == T_MULTU) overlap++;
      end
      if (!busy) busy_low++;
      step();
    end
    check("b2b.pulses", pulses, 32'd3);
    check("b2b.busy_low", busy_low, 32'd3);
    check("b2b.overlap", overlap, 32'd0);
    check("b2b.first", first_pulse, 32'd33);
    check("b2b.last", last_pulse, 32'd101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
